// File: rtl/los_biphase_tx_if.sv
// Signals between the LOS biphase serializer, its software control, the burst buffer
// read port and the LOS line drivers.
interface los_biphase_tx_if #(
    parameter int unsigned ADDR_W = 12
);
    logic              start_i;
    logic [ADDR_W-1:0] base_i;
    logic [ADDR_W-1:0] len_i;
    logic              abort_i;
    logic              rd_o;
    logic [ADDR_W-1:0] addr_o;
    logic [31:0]       dat_i;
    logic              busy_o;
    logic              done_o;
    logic              SDAT;
    logic              SCLK;
    logic              BIPHASE;

    modport slave (
        input  start_i, base_i, len_i, abort_i, dat_i,
        output rd_o, addr_o, busy_o, done_o, SDAT, SCLK, BIPHASE
    );

    modport master (
        output start_i, base_i, len_i, abort_i, dat_i,
        input  rd_o, addr_o, busy_o, done_o, SDAT, SCLK, BIPHASE
    );
endinterface

// File: rtl/los_biphase_tx.sv
// LOS serializer: streams N buffer words MSB-first as NRZ data, bit clock and Manchester,
// prefetching each next word during bit 31 of the current one.
module los_biphase_tx #(
    parameter int unsigned CLK_DIV = 8,
    parameter int unsigned ADDR_W  = 12
) (
    input  logic            clk_i,
    input  logic            nrst_i,
    los_biphase_tx_if.slave bus
);

    localparam logic [7:0]        CntMax  = 8'(CLK_DIV - 1);
    localparam logic [ADDR_W-1:0] WordOne = ADDR_W'(1);

    typedef enum logic [2:0] {StIdle, StPrefetch, StLoad, StShift, StDone} state_e;

    state_e            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              phase_q, phase_d;
    logic [4:0]        bidx_q, bidx_d;
    logic [31:0]       shift_q, shift_d;
    logic [31:0]       hold_q, hold_d;
    logic [ADDR_W-1:0] words_q, words_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rd_q, rd_d;
    logic              rd_pend_q, rd_pend_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              sdat_q, sdat_d;
    logic              sclk_q, sclk_d;
    logic              biph_q, biph_d;
    logic              prefetch;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        phase_d   = phase_q;
        bidx_d    = bidx_q;
        shift_d   = shift_q;
        hold_d    = rd_pend_q ? bus.dat_i : hold_q;
        words_d   = words_q;
        addr_d    = addr_q;
        rd_d      = 1'b0;
        rd_pend_d = rd_q;
        prefetch  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.start_i && !bus.abort_i) begin
                    state_d = StPrefetch;
                    words_d = bus.len_i;
                    addr_d  = bus.base_i;
                    rd_d    = (bus.len_i != '0);
                end
            end
            // An empty frame still spends this cycle here so done_o lands two cycles after start.
            StPrefetch: state_d = (words_q == '0) ? StDone : StLoad;
            StLoad: begin
                state_d  = StShift;
                shift_d  = hold_d;
                bidx_d   = 5'd31;
                cnt_d    = '0;
                phase_d  = 1'b0;
                prefetch = (words_q > WordOne);
            end
            StShift: begin
                if (cnt_q == CntMax) begin
                    cnt_d   = '0;
                    phase_d = ~phase_q;
                    if (phase_q) begin
                        if (bidx_q != 5'd0) begin
                            shift_d = {shift_q[30:0], 1'b0};
                            bidx_d  = bidx_q - 5'd1;
                        end else if (words_q > WordOne) begin
                            shift_d  = hold_q;
                            bidx_d   = 5'd31;
                            words_d  = words_q - WordOne;
                            prefetch = (words_d > WordOne);
                        end else begin
                            state_d = StDone;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (prefetch) begin
            rd_d   = 1'b1;
            addr_d = addr_q + WordOne;
        end

        if (bus.abort_i && (state_q != StIdle)) begin
            state_d   = StIdle;
            cnt_d     = '0;
            phase_d   = 1'b0;
            bidx_d    = '0;
            shift_d   = '0;
            hold_d    = '0;
            words_d   = '0;
            addr_d    = '0;
            rd_d      = 1'b0;
            rd_pend_d = 1'b0;
        end

        // Line outputs are flopped from next-state values so every edge sits on a half-bit.
        busy_d = (state_d != StIdle);
        done_d = (state_d == StDone);
        sdat_d = (state_d == StShift) & shift_d[31];
        sclk_d = (state_d == StShift) & phase_d;
        biph_d = (state_d == StShift) & (phase_d ? shift_d[31] : ~shift_d[31]);
    end

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            phase_q   <= 1'b0;
            bidx_q    <= '0;
            shift_q   <= '0;
            hold_q    <= '0;
            words_q   <= '0;
            addr_q    <= '0;
            rd_q      <= 1'b0;
            rd_pend_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sdat_q    <= 1'b0;
            sclk_q    <= 1'b0;
            biph_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            phase_q   <= phase_d;
            bidx_q    <= bidx_d;
            shift_q   <= shift_d;
            hold_q    <= hold_d;
            words_q   <= words_d;
            addr_q    <= addr_d;
            rd_q      <= rd_d;
            rd_pend_q <= rd_pend_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            sdat_q    <= sdat_d;
            sclk_q    <= sclk_d;
            biph_q    <= biph_d;
        end
    end

    assign bus.rd_o    = rd_q;
    assign bus.addr_o  = addr_q;
    assign bus.busy_o  = busy_q;
    assign bus.done_o  = done_q;
    assign bus.SDAT    = sdat_q;
    assign bus.SCLK    = sclk_q;
    assign bus.BIPHASE = biph_q;

endmodule

// File: tb/tb_los_biphase_tx.sv
// Bench for los_biphase_tx: table of frames plus abort, reset and ignored-start sequences,
// with read addresses and line triples checked against scoreboard queues.
module tb_los_biphase_tx;

    localparam int unsigned CLK_DIV = 2;
    localparam int unsigned ADDR_W  = 12;

    typedef struct packed {
        logic [11:0]      base;
        logic [11:0]      len;
        logic [7:0][31:0] w;
        logic [31:0]      done_lat;
    } vec_t;

    logic        clk;
    logic        nrst;
    int unsigned cyc;
    int unsigned n_chk;
    int unsigned n_pass;
    logic [31:0] mem [4096];
    logic [2:0]  exp_line [$];
    logic [11:0] exp_addr [$];
    vec_t        tbl [5];

    los_biphase_tx_if #(.ADDR_W(ADDR_W)) bus ();

    los_biphase_tx #(
        .CLK_DIV (CLK_DIV),
        .ADDR_W  (ADDR_W)
    ) dut (
        .clk_i  (clk),
        .nrst_i (nrst),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Buffer model: data one cycle after rd_o, junk otherwise so mistimed captures show up.
    always @(posedge clk) begin
        if (bus.rd_o) bus.dat_i <= mem[bus.addr_o];
        else          bus.dat_i <= 32'hDEAD_BEEF;
    end

    function automatic void chk(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    endfunction

    function automatic vec_t mk(input logic [11:0] b, input logic [11:0] l,
                                input logic [31:0] w0, input logic [31:0] w1,
                                input logic [31:0] w2, input logic [31:0] w3,
                                input int unsigned lat);
        vec_t v;
        v          = '0;
        v.base     = b;
        v.len      = l;
        v.w[0]     = w0;
        v.w[1]     = w1;
        v.w[2]     = w2;
        v.w[3]     = w3;
        v.done_lat = lat;
        return v;
    endfunction

    // Expected {SDAT, SCLK, BIPHASE} per cycle: bit 1 -> low/high, bit 0 -> high/low.
    task automatic push_word(input logic [31:0] w);
        for (int b = 31; b >= 0; b--) begin
            for (int j = 0; j < 2 * int'(CLK_DIV); j++) begin
                logic bt, hf;
                bt = w[b];
                hf = (j >= int'(CLK_DIV));
                exp_line.push_back({bt, hf, hf ? bt : ~bt});
            end
        end
    endtask

    always @(negedge clk) begin : mon
        logic [2:0] line;
        if (bus.rd_o) begin
            if (exp_addr.size() == 0) chk("rd_unexpected", bus.rd_o, 0);
            else                      chk("rd_addr", bus.addr_o, exp_addr.pop_front());
        end
        line = {bus.SDAT, bus.SCLK, bus.BIPHASE};
        if (line != 3'b000) begin
            if (exp_line.size() == 0) chk("line_unexpected", line, 0);
            else                      chk("line_bits", line, exp_line.pop_front());
        end
    end

    task automatic launch(input vec_t v, output int unsigned c0);
        for (int i = 0; i < int'(v.len); i++) begin
            logic [11:0] a;
            a      = v.base + 12'(i);
            mem[a] = v.w[3'(i)];
            exp_addr.push_back(a);
            push_word(v.w[3'(i)]);
        end
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.base_i  = v.base;
        bus.len_i   = v.len;
        c0          = cyc;
        @(negedge clk);
        bus.start_i = 1'b0;
        chk("busy_after_start", bus.busy_o, 1);
    endtask

    task automatic finish_frame(input vec_t v, input int unsigned c0);
        bit          seen;
        int unsigned lat;
        seen = 1'b0;
        while (!seen && (cyc - c0) < v.done_lat + 50) begin
            @(negedge clk);
            if (bus.done_o) seen = 1'b1;
        end
        lat = cyc - c0;
        chk("done_seen", seen, 1);
        if (seen) chk("done_latency", lat, v.done_lat);
        @(negedge clk);
        chk("done_pulse", bus.done_o, 0);
        chk("busy_drop", bus.busy_o, 0);
        chk("line_idle", {bus.SDAT, bus.SCLK, bus.BIPHASE}, 0);
        chk("rd_count", exp_addr.size(), 0);
        chk("bits_left", exp_line.size(), 0);
    endtask

    initial begin
        int unsigned c0;
        int unsigned ndone;
        vec_t        va;

        n_chk       = 0;
        n_pass      = 0;
        cyc         = 0;
        nrst        = 1'b0;
        bus.start_i = 1'b0;
        bus.abort_i = 1'b0;
        bus.base_i  = '0;
        bus.len_i   = '0;
        for (int i = 0; i < 4096; i++) mem[i] = 32'(i) * 32'h0101_0101;

        // len*64*CLK_DIV + 3 cycles from start to done_o; empty frame is 2.
        tbl[0] = mk(12'h010, 12'd1, 32'hA5A5_0F0F, 0, 0, 0, 131);
        tbl[1] = mk(12'h010, 12'd3, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0001, 0, 387);
        tbl[2] = mk(12'hFFE, 12'd4, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0F1E_2D3C,
                    32'hC3D2_E1F0, 515);
        tbl[3] = mk(12'h020, 12'd0, 0, 0, 0, 0, 2);
        tbl[4] = mk(12'h040, 12'd2, 32'h6DB6_DB6D, 32'h0123_4567, 0, 0, 259);

        repeat (3) @(negedge clk);
        chk("reset_outputs", {bus.rd_o, bus.busy_o, bus.done_o, bus.SDAT, bus.SCLK,
                              bus.BIPHASE, bus.addr_o}, 0);
        nrst = 1'b1;
        @(negedge clk);
        chk("post_reset_idle", {bus.busy_o, bus.SDAT, bus.SCLK, bus.BIPHASE}, 0);

        for (int i = 0; i < 4; i++) begin
            launch(tbl[i], c0);
            finish_frame(tbl[i], c0);
        end

        // Abort part-way through word 1 of a five-word frame, then re-arm.
        va = mk(12'h100, 12'd5, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333,
                32'h4444_4444, 0);
        va.w[4] = 32'h5555_5555;
        launch(va, c0);
        while ((cyc - c0) < 171) @(negedge clk);
        bus.abort_i = 1'b1;
        @(negedge clk);
        bus.abort_i = 1'b0;
        chk("abort_outputs", {bus.rd_o, bus.busy_o, bus.done_o, bus.SDAT, bus.SCLK,
                              bus.BIPHASE}, 0);
        chk("abort_rd_issued", 5 - exp_addr.size(), 3);
        exp_addr.delete();
        exp_line.delete();
        ndone = 0;
        repeat (300) begin
            @(negedge clk);
            if (bus.done_o) ndone++;
        end
        chk("abort_no_done", ndone, 0);
        launch(tbl[4], c0);
        finish_frame(tbl[4], c0);

        // Asynchronous reset in the middle of a word.
        launch(tbl[1], c0);
        repeat (100) @(negedge clk);
        nrst = 1'b0;
        #1;
        chk("async_reset", {bus.rd_o, bus.busy_o, bus.done_o, bus.SDAT, bus.SCLK,
                            bus.BIPHASE}, 0);
        exp_addr.delete();
        exp_line.delete();
        repeat (2) @(negedge clk);
        nrst = 1'b1;

        // A second start while busy must not disturb the running frame.
        va = mk(12'h200, 12'd2, 32'hCAFE_F00D, 32'h5A5A_A5A5, 0, 0, 259);
        mem[12'h300] = 32'hFFFF_0000;
        launch(va, c0);
        repeat (60) @(negedge clk);
        bus.start_i = 1'b1;
        bus.base_i  = 12'h300;
        bus.len_i   = 12'd1;
        @(negedge clk);
        bus.start_i = 1'b0;
        finish_frame(va, c0);

        // Abort and start together in IDLE: abort wins, nothing starts.
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.abort_i = 1'b1;
        bus.len_i   = 12'd1;
        @(negedge clk);
        bus.start_i = 1'b0;
        bus.abort_i = 1'b0;
        chk("abort_start_idle", bus.busy_o, 0);
        repeat (3) @(negedge clk);
        chk("abort_start_quiet", {bus.busy_o, bus.SDAT, bus.SCLK, bus.BIPHASE}, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
